data_array_nway: RTL and testbench
==================================

DATA_ARRAY_NWAY -- requirements
Module: data_array_nway

Interface
REQ-001 Parameter s_offset, default 5, meaning log2 of line size in bytes.
REQ-002 Parameter s_index, default 3, meaning log2 of number of sets.
REQ-003 Parameter num_ways, default 2, meaning number of ways (>=1).
REQ-004 Derived constants SHALL be s_mask = 2**s_offset, s_line = 8*s_mask, num_sets = 2**s_index, s_way = max(1, clog2(num_ways)).
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 init  input  1  pulse requesting a runtime clear sweep of the whole array.
REQ-008 read  input  1  read request for set rindex, all ways.
REQ-009 rindex  input  s_index  read set index.
REQ-010 write_en  input  s_mask  per-byte write enables.
REQ-011 windex  input  s_index  write set index.
REQ-012 wway  input  s_way  write way select.
REQ-013 datain  input  s_line  write data.
REQ-014 dataout  output  num_ways*s_line  registered read data; way w occupies bits [w*s_line +: s_line].
REQ-015 rvalid  output  1  dataout holds the result of the read accepted last cycle.
REQ-016 busy  output  1  clear sweep in progress; requests are ignored.

Function
REQ-017 Block SHALL have two states: CLEAR and READY.
REQ-018 In CLEAR, a sweep counter SHALL zero all bytes of every way of set sweep_cnt each cycle, then increment it.
REQ-019 CLEAR SHALL go to READY on the cycle sweep_cnt = num_sets-1 is written, so a sweep lasts exactly num_sets cycles.
REQ-020 busy SHALL be 1 exactly while in CLEAR.
REQ-021 In CLEAR, read and write_en SHALL be ignored, and rvalid SHALL be 0.
REQ-022 init=1 in READY SHALL enter CLEAR next cycle with sweep_cnt=0; that cycle's read and write SHALL still be performed.
REQ-023 init=1 in CLEAR SHALL restart the sweep at sweep_cnt=0.
REQ-024 In READY, for each byte i with write_en[i]=1, byte i of line [wway][windex] SHALL take datain byte i at the clock edge; other bytes SHALL be unchanged.
REQ-025 In READY with read=1, dataout SHALL be updated one cycle later with all ways of set rindex; rvalid SHALL be 1 that cycle.
REQ-026 Read and write in the same cycle with rindex = windex SHALL forward: for way wway, each enabled byte of dataout SHALL return the new datain byte (write-first).
REQ-027 With read=0, dataout SHALL hold its previous value and rvalid SHALL be 0 the next cycle.
REQ-028 wway >= num_ways SHALL make the write a no-op.
REQ-029 Same-cycle rindex != windex reads SHALL return stored (pre-write) data.

Reset
REQ-030 rst=1 SHALL force CLEAR with sweep_cnt=0, dataout=0, rvalid=0 and busy=1 on the next cycle, regardless of state.
REQ-031 rst SHALL take priority over init, read and write.
REQ-032 Array contents SHALL be guaranteed zero only after the sweep completes: busy falls num_sets cycles after rst is deasserted.

Structure
REQ-033 State enum and derived-width helper constants SHALL live in the shared cache package (cache_types_pkg).
REQ-034 One sub-module data_way (single-way byte-enable storage with a combinational read port) SHALL be instantiated num_ways times; the sweep FSM, forwarding and output register SHALL be in data_array_nway.
REQ-035 Storage SHALL be flip-flop based, with no RAM inference.

Verification (s_offset=5, s_index=3, num_ways=2)
REQ-036 rst for 1 cycle -> busy=1 for exactly 8 cycles, then 0; a read of every set in both ways returns all zeros.
REQ-037 Write way1 set3 write_en=0x0000000F datain bytes0-3=0xDEADBEEF, then read set3 -> next cycle way1 bytes0-3=0xDEADBEEF, other bytes and way0=0, rvalid=1.
REQ-038 Same-cycle read set5 and write way0 set5 write_en=0x1 byte0=0xA5 -> next-cycle dataout way0 byte0=0xA5, rvalid=1.
REQ-039 Read set3, then read=0 for 3 cycles while writing set3 -> dataout unchanged and rvalid=0 for those 3 cycles.
REQ-040 init pulse mid-operation with set7 holding nonzero data -> busy for 8 cycles; reads during busy give rvalid=0; set7 reads zero afterwards.
REQ-041 rst asserted in the 4th cycle of a sweep -> sweep restarts, and busy stays 1 for 8 more cycles.

Source files
------------

// File: rtl/cache_types_pkg.sv
// Shared cache types: array sweep FSM states and derived-width helpers.
package cache_types_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } array_state_e;

  // Way-select width; a single-way array still carries a 1-bit select.
  function automatic int way_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int line_bits(input int off);
    return 8 * (2 ** off);
  endfunction

endpackage

// File: rtl/data_way.sv
// One way of the data array: flop-based lines with byte enables, a
// whole-line clear port for the sweep, and a combinational read port.
module data_way
  import cache_types_pkg::*;
#(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  localparam int s_mask   = 2 ** s_offset,
  localparam int s_line   = line_bits(s_offset),
  localparam int num_sets = 2 ** s_index
) (
  input  logic                clk,
  input  logic                clear,
  input  logic [s_index-1:0]  clear_index,
  input  logic [s_mask-1:0]   write_en,
  input  logic [s_index-1:0]  windex,
  input  logic [s_line-1:0]   datain,
  input  logic [s_index-1:0]  rindex,
  output logic [s_line-1:0]   dataout
);

  logic [s_line-1:0] lines [num_sets];

  for (genvar gi = 0; gi < num_sets; gi++) begin : g_set
    logic [s_line-1:0] line_reg;
    logic              clear_hit;
    logic              write_hit;

    assign clear_hit = clear && (clear_index == s_index'(gi));
    assign write_hit = (windex == s_index'(gi));

    // Clear wins over a write; the parent never issues both at once anyway.
    always_ff @(posedge clk) begin
      for (int b = 0; b < s_mask; b++) begin
        if (clear_hit) begin
          line_reg[b*8 +: 8] <= 8'h00;
        end else if (write_hit && write_en[b]) begin
          line_reg[b*8 +: 8] <= datain[b*8 +: 8];
        end
      end
    end

    assign lines[gi] = line_reg;
  end

  assign dataout = lines[rindex];

endmodule

// File: rtl/data_array_nway.sv
// N-way cache data array: runtime clear sweep FSM, write-first forwarding
// of same-set writes, and a registered all-ways read port.
module data_array_nway
  import cache_types_pkg::*;
#(
  parameter int s_offset = 5,
  parameter int s_index  = 3,
  parameter int num_ways = 2,
  localparam int s_mask   = 2 ** s_offset,
  localparam int s_line   = line_bits(s_offset),
  localparam int num_sets = 2 ** s_index,
  localparam int s_way    = way_bits(num_ways)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         init,
  input  logic                         read,
  input  logic [s_index-1:0]           rindex,
  input  logic [s_mask-1:0]            write_en,
  input  logic [s_index-1:0]           windex,
  input  logic [s_way-1:0]             wway,
  input  logic [s_line-1:0]            datain,
  output logic [num_ways*s_line-1:0]   dataout,
  output logic                         rvalid,
  output logic                         busy
);

  array_state_e       state_reg, state_next;
  logic [s_index-1:0] sweep_cnt_reg, sweep_cnt_next;

  logic sweeping;
  logic req_ok;
  logic fwd_hit;

  logic [s_line-1:0]          way_rdata [num_ways];
  logic [num_ways*s_line-1:0] fwd_data;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= CLEAR;
      sweep_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      sweep_cnt_reg <= sweep_cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next     = state_reg;
    sweep_cnt_next = sweep_cnt_reg;
    case (state_reg)
      CLEAR: begin
        if (init) begin
          sweep_cnt_next = '0;
        end else if (sweep_cnt_reg == s_index'(num_sets - 1)) begin
          state_next     = READY;
          sweep_cnt_next = '0;
        end else begin
          sweep_cnt_next = sweep_cnt_reg + s_index'(1);
        end
      end
      READY: begin
        if (init) begin
          state_next     = CLEAR;
          sweep_cnt_next = '0;
        end
      end
      default: begin
        state_next     = CLEAR;
        sweep_cnt_next = '0;
      end
    endcase
  end

  // Output / control decode
  always_comb begin
    sweeping = (state_reg == CLEAR);
    busy     = sweeping;
    req_ok   = (state_reg == READY) && !rst;
    fwd_hit  = (rindex == windex);
  end

  for (genvar gi = 0; gi < num_ways; gi++) begin : g_way
    logic              way_sel;
    logic [s_mask-1:0] way_we;

    // Out-of-range wway matches no way, so such writes are dropped.
    assign way_sel = (wway == s_way'(gi));
    assign way_we  = (req_ok && way_sel) ? write_en : '0;

    data_way #(
      .s_offset (s_offset),
      .s_index  (s_index)
    ) u_way (
      .clk         (clk),
      .clear       (sweeping),
      .clear_index (sweep_cnt_reg),
      .write_en    (way_we),
      .windex      (windex),
      .datain      (datain),
      .rindex      (rindex),
      .dataout     (way_rdata[gi])
    );

    for (genvar gb = 0; gb < s_mask; gb++) begin : g_byte
      assign fwd_data[gi*s_line + gb*8 +: 8] =
        (fwd_hit && way_sel && write_en[gb]) ? datain[gb*8 +: 8]
                                             : way_rdata[gi][gb*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dataout <= '0;
      rvalid  <= 1'b0;
    end else if (req_ok && read) begin
      dataout <= fwd_data;
      rvalid  <= 1'b1;
    end else begin
      rvalid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_array_nway.sv
// Scoreboard bench for data_array_nway at s_offset=5, s_index=3, num_ways=2.
module tb_data_array_nway;

  localparam int NSETS = 8;
  localparam int NB    = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         init = 1'b0;
  logic         read = 1'b0;
  logic [2:0]   rindex = '0;
  logic [31:0]  write_en = '0;
  logic [2:0]   windex = '0;
  logic [0:0]   wway = '0;
  logic [255:0] datain = '0;
  logic [511:0] dataout;
  logic         rvalid;
  logic         busy;

  data_array_nway dut (
    .clk      (clk),
    .rst      (rst),
    .init     (init),
    .read     (read),
    .rindex   (rindex),
    .write_en (write_en),
    .windex   (windex),
    .wway     (wway),
    .datain   (datain),
    .dataout  (dataout),
    .rvalid   (rvalid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [255:0] m_mem [2][NSETS];
  logic [511:0] m_dataout = '0;
  logic [511:0] exp_q [$];
  int           m_busy_left = 0;
  bit           m_known = 0;
  logic         last_busy;

  // One clock cycle: drive at negedge, advance the model, check after posedge.
  task automatic step(input logic r, input logic [2:0] ri, input logic [31:0] we,
                      input logic [2:0] wi, input logic wy, input logic [255:0] d,
                      input logic in, input logic rs);
    logic         exp_valid;
    logic [511:0] exp_line;
    logic [511:0] got;
    @(negedge clk);
    last_busy = busy;
    if (m_known) begin
      tests_run++;
      if (busy !== (m_busy_left > 0)) begin
        tests_failed++;
        $display("FAIL busy: got %b expected %b", busy, (m_busy_left > 0));
      end
    end
    read = r; rindex = ri; write_en = we; windex = wi; wway = wy; datain = d;
    init = in; rst = rs;

    exp_valid = !rs && (m_busy_left == 0) && r;
    if (!rs && m_busy_left == 0) begin
      if (r) begin
        for (int w = 0; w < 2; w++) begin
          exp_line[w*256 +: 256] = m_mem[w][ri];
          if (w == int'(wy) && ri == wi)
            for (int b = 0; b < NB; b++)
              if (we[b]) exp_line[w*256 + b*8 +: 8] = d[b*8 +: 8];
        end
        exp_q.push_back(exp_line);
      end
      for (int b = 0; b < NB; b++)
        if (we[b]) m_mem[wy][wi][b*8 +: 8] = d[b*8 +: 8];
    end
    if (m_busy_left > 0) begin
      m_mem[0][NSETS - m_busy_left] = '0;
      m_mem[1][NSETS - m_busy_left] = '0;
    end
    if (rs || in) m_busy_left = NSETS;
    else if (m_busy_left > 0) m_busy_left--;
    if (rs) begin
      m_dataout = '0;
      exp_q.delete();
      m_known = 1;
    end

    @(posedge clk);
    #1;
    tests_run++;
    if (rvalid !== exp_valid) begin
      tests_failed++;
      $display("FAIL rvalid: got %b expected %b", rvalid, exp_valid);
    end
    if (exp_valid && exp_q.size() > 0) m_dataout = exp_q.pop_front();
    got = dataout;
    tests_run++;
    if (got !== m_dataout) begin
      tests_failed++;
      $display("FAIL dataout: got %h expected %h", got, m_dataout);
    end
  endtask

  task automatic idle();
    step(1'b0, 3'd0, 32'h0, 3'd0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // Counts busy cycles from the next cycle on; bounded to 20 cycles.
  task automatic count_busy(input string name, input int expect_cycles);
    int n = 0;
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      idle();
      if (last_busy) n++;
      else done = 1;
    end
    tests_run++;
    if (n != expect_cycles || !done) begin
      tests_failed++;
      $display("FAIL %s: busy cycles got %0d expected %0d", name, n, expect_cycles);
    end
  endtask

  task automatic test_reset();
    step(1'b0, 3'd0, 32'h0, 3'd0, 1'b0, '0, 1'b0, 1'b1);
    tests_run++;
    if (rvalid !== 1'b0 || busy !== 1'b1 || dataout !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: got busy=%b rvalid=%b expected busy=1 rvalid=0 dataout=0", busy, rvalid);
    end
    count_busy("reset_sweep", NSETS);
    for (int s = 0; s < NSETS; s++)
      step(1'b1, 3'(s), 32'h0, 3'd0, 1'b0, '0, 1'b0, 1'b0);
    $display("[TB] test_reset done");
  endtask

  task automatic test_byte_write();
    step(1'b0, 3'd0, 32'h0000000F, 3'd3, 1'b1, 256'hDEADBEEF, 1'b0, 1'b0);
    step(1'b1, 3'd3, 32'h0, 3'd0, 1'b0, '0, 1'b0, 1'b0);
    tests_run++;
    if (dataout[256 +: 32] !== 32'hDEADBEEF || dataout[511:288] !== '0 || dataout[255:0] !== '0) begin
      tests_failed++;
      $display("FAIL byte_write: got %h expected way1 bytes0-3 DEADBEEF else 0", dataout);
    end
    $display("[TB] test_byte_write done");
  endtask

  task automatic test_forward();
    step(1'b1, 3'd5, 32'h1, 3'd5, 1'b0, 256'hA5, 1'b0, 1'b0);
    tests_run++;
    if (dataout[7:0] !== 8'hA5 || rvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL forward: got byte0=%h rvalid=%b expected a5 1", dataout[7:0], rvalid);
    end
    $display("[TB] test_forward done");
  endtask

  task automatic test_hold();
    step(1'b1, 3'd3, 32'h0, 3'd0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 3'd3, 32'hFFFF0000, 3'd3, 1'(i), {8{$urandom()}}, 1'b0, 1'b0);
    step(1'b1, 3'd3, 32'h0, 3'd0, 1'b0, '0, 1'b0, 1'b0);
    $display("[TB] test_hold done");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      logic [2:0] ri;
      ri = 3'($urandom_range(0, 7));
      step(1'($urandom), ri, $urandom(), ($urandom_range(0, 2) == 0) ? ri : 3'($urandom),
           1'($urandom), {8{$urandom()}}, 1'b0, 1'b0);
    end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_init();
    step(1'b0, 3'd0, 32'hFFFFFFFF, 3'd7, 1'b0, {8{32'h1234_5678}}, 1'b0, 1'b0);
    step(1'b0, 3'd0, 32'hFFFFFFFF, 3'd7, 1'b1, {8{32'h9ABC_DEF0}}, 1'b0, 1'b0);
    step(1'b1, 3'd7, 32'h0, 3'd0, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < NSETS; i++)
      step(1'b1, 3'd7, 32'hFFFFFFFF, 3'd7, 1'b0, {8{32'hFFFF_FFFF}}, 1'b0, 1'b0);
    step(1'b1, 3'd7, 32'h0, 3'd0, 1'b0, '0, 1'b0, 1'b0);
    tests_run++;
    if (dataout !== '0 || rvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL init_clear: got %h rvalid=%b expected 0 1", dataout, rvalid);
    end
    $display("[TB] test_init done");
  endtask

  task automatic test_rst_mid_sweep();
    step(1'b0, 3'd0, 32'hFF, 3'd2, 1'b1, {8{$urandom()}}, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) idle();
    step(1'b1, 3'd0, 32'h0, 3'd0, 1'b0, '0, 1'b0, 1'b1);
    count_busy("rst_mid_sweep", NSETS);
    for (int s = 0; s < NSETS; s++)
      step(1'b1, 3'(s), 32'h0, 3'd0, 1'b0, '0, 1'b0, 1'b0);
    $display("[TB] test_rst_mid_sweep done");
  endtask

  initial begin
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < NSETS; s++) m_mem[w][s] = '0;
    test_reset();
    test_byte_write();
    test_forward();
    test_hold();
    test_back_to_back();
    test_init();
    test_rst_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
